// File: rtl/btn_pkg.sv
// ============================================================================
// Module      : btn_pkg
// Description : Shared definitions for the button conditioner: per-channel
//               FSM state encoding and a counter width helper.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

package btn_pkg;

  // Per-channel FSM state encoding
  typedef logic [1:0] btn_state_t;

  localparam btn_state_t ST_IDLE   = 2'd0;
  localparam btn_state_t ST_FIRE   = 2'd1;
  localparam btn_state_t ST_HOLD   = 2'd2;
  localparam btn_state_t ST_REPEAT = 2'd3;

  // Number of bits needed to hold values 0..max_value (never less than 1)
  function automatic int unsigned bit_width(input int unsigned max_value);
    int unsigned w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((max_value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage : btn_pkg

`default_nettype wire

// File: rtl/button_channel.sv
// ============================================================================
// Module      : button_channel
// Description : One button channel: 2-flop synchroniser, debounce counter,
//               press/release/repeat FSM with registered outputs.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module button_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BUTTON_N,
  output logic PRESS_PULSE,
  output logic RELEASE_PULSE,
  output logic HELD
);

  // The debounce counter never holds DEBOUNCE_CYCLES itself: it clears on the
  // cycle the count would reach it.
  localparam int unsigned c_DB_W    = bit_width(DEBOUNCE_CYCLES - 1);
  localparam int unsigned c_RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - 1)
                                                                   : (REPEAT_RATE - 1);
  localparam int unsigned c_RPT_W   = bit_width(c_RPT_MAX);

  localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_DELAY_LOAD = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_RATE_LOAD  = c_RPT_W'(REPEAT_RATE - 1);
  localparam logic               c_REPEAT_ON  = (REPEAT_EN != 0);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db_state;   // 1 = debounced pressed
  logic [c_DB_W-1:0]  r_db_cnt;
  btn_state_t         r_state;
  logic [c_RPT_W-1:0] r_rpt_cnt;

  logic w_pressed_now;
  logic w_differ;

  assign w_pressed_now = ~r_sync2;
  assign w_differ      = (w_pressed_now != r_db_state);

  // Two-flop synchroniser for the asynchronous raw button (idle high)
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= BUTTON_N;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive disagreeing cycles, flip the level on the last
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_db_state <= 1'b0;
      r_db_cnt   <= '0;
    end else if (!w_differ) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_DB_LAST) begin
      r_db_state <= w_pressed_now;
      r_db_cnt   <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + c_DB_W'(1);
    end
  end

  // Press/release/repeat FSM; the repeat counter is loaded on entry to FIRE or
  // REPEAT and counts down through that pulse cycle, so repeats land exactly
  // REPEAT_DELAY / REPEAT_RATE cycles after the previous pulse.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state       <= ST_IDLE;
      r_rpt_cnt     <= '0;
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      HELD          <= 1'b0;
    end else begin
      PRESS_PULSE   <= 1'b0;
      RELEASE_PULSE <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_db_state) begin
            r_state     <= ST_FIRE;
            PRESS_PULSE <= 1'b1;
            HELD        <= 1'b1;
            r_rpt_cnt   <= c_DELAY_LOAD;
          end
        end
        ST_FIRE, ST_REPEAT: begin
          r_state   <= ST_HOLD;
          r_rpt_cnt <= r_rpt_cnt - c_RPT_W'(1);
        end
        ST_HOLD: begin
          if (!r_db_state) begin
            r_state       <= ST_IDLE;
            RELEASE_PULSE <= 1'b1;
            HELD          <= 1'b0;
          end else if (c_REPEAT_ON && (r_rpt_cnt == '0)) begin
            r_state     <= ST_REPEAT;
            PRESS_PULSE <= 1'b1;
            r_rpt_cnt   <= c_RATE_LOAD;
          end else if (r_rpt_cnt != '0) begin
            r_rpt_cnt <= r_rpt_cnt - c_RPT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          HELD    <= 1'b0;
        end
      endcase
    end
  end

endmodule : button_channel

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : NUM_BTN independent debounced button channels with press,
//               release and optional auto-repeat pulses plus a combined
//               any-press flag.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
`default_nettype none

module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_EN       = 0,
  parameter int unsigned REPEAT_DELAY    = 50,
  parameter int unsigned REPEAT_RATE     = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BUTTON_N,
  output logic [NUM_BTN-1:0] PRESS_PULSE,
  output logic [NUM_BTN-1:0] RELEASE_PULSE,
  output logic [NUM_BTN-1:0] HELD,
  output logic               ANY_PRESS
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_chan (
      .CLK           (CLK),
      .RESET         (RESET),
      .BUTTON_N      (BUTTON_N[i]),
      .PRESS_PULSE   (PRESS_PULSE[i]),
      .RELEASE_PULSE (RELEASE_PULSE[i]),
      .HELD          (HELD[i])
    );
  end

  // Pulse bits are registered, so the OR is glitch-free
  assign ANY_PRESS = |PRESS_PULSE;

endmodule : button_conditioner

`default_nettype wire

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Multi-channel successor to the single-button pulse shaper. Each channel synchronises an active-low raw button, debounces it with a programmable stability count, and emits one-cycle press and release pulses. An optional auto-repeat mode re-fires the press pulse while the button is held. Sits between board push-buttons and the prime-prediction control FSMs; replaces per-button shaper instances.

Parameters:
NUM_BTN, 4, number of independent button channels (>=1)
DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes (>=1)
REPEAT_EN, 0, 1 enables auto-repeat on all channels
REPEAT_DELAY, 50, cycles from the initial press pulse to the first repeat pulse (>=2)
REPEAT_RATE, 10, cycles between later repeat pulses (>=2)

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-low reset
BUTTON_N  input  NUM_BTN  raw asynchronous buttons; 0 = pressed
PRESS_PULSE  output  NUM_BTN  one-cycle pulse per press, and per repeat when enabled
RELEASE_PULSE  output  NUM_BTN  one-cycle pulse per debounced release
HELD  output  NUM_BTN  debounced level; 1 = pressed
ANY_PRESS  output  1  OR of all PRESS_PULSE bits

Behaviour:
- Reset: RESET sampled 0 at posedge -> sync flops = 1, debounced state = released, counters = 0, FSM = IDLE; all outputs 0 in the following cycle. Reset mid-operation aborts any pulse or repeat sequence immediately.
- Synchroniser: 2-flop chain per channel; reset value 1.
- Debounce: counter increments on each cycle where the synchronised input differs from the debounced state. It clears on any cycle where they match. When the count reaches DEBOUNCE_CYCLES, the debounced state flips and the counter clears. A low glitch shorter than DEBOUNCE_CYCLES cycles produces no output.
- Latency: count the first posedge that samples BUTTON_N[i]=0 as edge 1. With a steady low input, PRESS_PULSE[i] and HELD[i] go high after edge DEBOUNCE_CYCLES+3. Release latency is identical for RELEASE_PULSE and for HELD falling.
- Per-channel FSM (registered outputs):
  IDLE: outputs 0; debounced pressed -> FIRE.
  FIRE: PRESS_PULSE=1 for one cycle; load the repeat counter with REPEAT_DELAY-1; -> HOLD.
  HOLD: HELD=1. Debounced release -> RELEASE_PULSE for one cycle, -> IDLE. Otherwise, if REPEAT_EN and the repeat counter = 0 -> REPEAT; else decrement.
  REPEAT: PRESS_PULSE=1 for one cycle; reload the counter with REPEAT_RATE-1; -> HOLD. A release seen in REPEAT is handled on the next HOLD cycle.
- Repeat timing: with REPEAT_EN=1 and the button held, pulses occur at P, P+REPEAT_DELAY, then every REPEAT_RATE cycles, where P is the initial press-pulse cycle. With REPEAT_EN=0, exactly one press pulse per press.
- PRESS_PULSE and RELEASE_PULSE on the same channel are never high together.
- Button held through reset deassertion: treated as a fresh press, so a press pulse follows after the normal latency.
- Channels are fully independent. Simultaneous presses each produce their own pulse in the same cycle; ANY_PRESS=1 for that single cycle.
- Counter widths: clog2 of (max value + 1); no counter wraps.

Decomposition:
- Shared package btn_pkg: FSM state encoding (IDLE, FIRE, HOLD, REPEAT as 2-bit localparams) and a clog2 width function.
- Sub-module button_channel: synchroniser, debounce counter, FSM and repeat counter for one button. The top level instantiates NUM_BTN copies in a generate loop and ORs the pulses to form ANY_PRESS.

Test Plan:
- Common settings for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_EN=0 unless stated, NUM_BTN=4.
- Clean press: hold BUTTON_N[0]=0 for 30 cycles, then release -> PRESS_PULSE[0] high only after edge 7; HELD[0] 1 from edge 7 until 7 edges after release; one RELEASE_PULSE[0].
- Bounce: toggle BUTTON_N[1] low 2 cycles / high 1 cycle five times, then steady low -> exactly one PRESS_PULSE[1], 7 edges after the steady low starts.
- Auto-repeat: REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=5; hold 40 cycles -> pulses at P, P+10, P+15, P+20, ...; no pulses after the release is debounced.
- Simultaneous: drive BUTTON_N=4'b0000 at one edge -> all four PRESS_PULSE bits high in the same cycle; ANY_PRESS=1 for one cycle.
- Reset mid-hold: assert RESET=0 during HOLD -> outputs 0 next cycle. Keep the button low and deassert reset -> a new PRESS_PULSE 7 edges later.
